// File: rtl/regfile_mp.sv
// Multi-port register file with per-entry busy scoreboard, write-to-read bypass,
// optional hard-wired zero entry and a sequential bulk-clear engine.
module regfile_mp #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DWIDTH-1:0]        Data_In,
  input  logic [AWIDTH-1:0]        Waddr,
  input  logic                     W_en,
  input  logic                     Rsv_en,
  input  logic [AWIDTH-1:0]        Rsv_addr,
  input  logic [NREAD*AWIDTH-1:0]  Rd_Addr,
  output logic [NREAD*DWIDTH-1:0]  Data_out,
  output logic [NREAD-1:0]         Rd_busy,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH-1:0] CNT_LAST = AWIDTH'(DEPTH - 1);

  // state   | meaning
  // S_IDLE  | normal operation: writes, reservations and clear requests accepted
  // S_CLEAR | sweeping cnt_q over every entry; writes/reservations dropped
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q;
  logic [AWIDTH-1:0] cnt_q;
  logic              clr_busy_q;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;

  logic is_idle;
  logic wr_ok;
  logic rsv_ok;

  assign is_idle = (state_q == S_IDLE);
  assign wr_ok   = W_en && is_idle && !reset && !((ZERO_REG != 0) && (Waddr == '0));
  assign rsv_ok  = Rsv_en && is_idle && !reset && !((ZERO_REG != 0) && (Rsv_addr == '0));
  assign clr_busy = clr_busy_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q     <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_ok) begin
            mem_q[Waddr]  <= Data_In;
            busy_q[Waddr] <= 1'b0;
          end
          // Placed after the write so a same-address reservation wins.
          if (rsv_ok) busy_q[Rsv_addr] <= 1'b1;
          if (clr_req) begin
            state_q    <= S_CLEAR;
            cnt_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          mem_q[cnt_q]  <= '0;
          busy_q[cnt_q] <= 1'b0;
          cnt_q         <= cnt_q + AWIDTH'(1);
          if (cnt_q == CNT_LAST) begin
            state_q    <= S_IDLE;
            clr_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AWIDTH-1:0] ra;
    logic [DWIDTH-1:0] rdata;
    logic              rbusy;

    assign ra = Rd_Addr[k*AWIDTH +: AWIDTH];

    always_comb begin
      rdata = mem_q[ra];
      rbusy = busy_q[ra];
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rdata = '0;
        rbusy = 1'b0;
      end else if ((BYPASS != 0) && wr_ok && (Waddr == ra)) begin
        rdata = Data_In;
        rbusy = rsv_ok && (Rsv_addr == ra);
      end
    end

    assign Data_out[k*DWIDTH +: DWIDTH] = rdata;
    assign Rd_busy[k]                   = rbusy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector table, hand-written clear/reset sequences and a randomised
// run against a behavioural model of regfile_mp (default parameters).
module tb_regfile_mp;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] Data_In;
  logic [4:0]  Waddr;
  logic        W_en;
  logic        Rsv_en;
  logic [4:0]  Rsv_addr;
  logic [9:0]  Rd_Addr;
  logic [63:0] Data_out;
  logic [1:0]  Rd_busy;
  logic        clr_req;
  logic        clr_busy;

  regfile_mp dut (
    .clock    (clock),
    .reset    (reset),
    .Data_In  (Data_In),
    .Waddr    (Waddr),
    .W_en     (W_en),
    .Rsv_en   (Rsv_en),
    .Rsv_addr (Rsv_addr),
    .Rd_Addr  (Rd_Addr),
    .Data_out (Data_out),
    .Rd_busy  (Rd_busy),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rsv;
    logic [4:0]  raddr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t vecs [18];

  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  logic        m_clr;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    reset = 1'b0; W_en = 1'b0; Rsv_en = 1'b0; clr_req = 1'b0;
    Waddr = '0; Rsv_addr = '0; Data_In = '0;
  endtask

  task automatic setrd(input logic [4:0] a0, input logic [4:0] a1);
    Rd_Addr = {a1, a0};
  endtask

  function automatic logic [31:0] rd0();
    return Data_out[31:0];
  endfunction

  function automatic logic [31:0] rd1();
    return Data_out[63:32];
  endfunction

  // Expected combinational read for the current inputs and model state.
  task automatic exp_rd(input logic [4:0] a, output logic [31:0] d, output logic b);
    if (a == 5'd0) begin
      d = '0; b = 1'b0;
    end else if (!m_clr && !reset && W_en && Waddr == a) begin
      d = Data_In; b = Rsv_en && (Rsv_addr == a);
    end else begin
      d = m_mem[a]; b = m_busy[a];
    end
  endtask

  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_busy = '0; m_clr = 1'b0; m_cnt = 0;
    end else if (!m_clr) begin
      if (W_en && Waddr != 5'd0) begin
        m_mem[Waddr] = Data_In; m_busy[Waddr] = 1'b0;
      end
      if (Rsv_en && Rsv_addr != 5'd0) m_busy[Rsv_addr] = 1'b1;
      if (clr_req) begin
        m_clr = 1'b1; m_cnt = 0;
      end
    end else begin
      m_mem[m_cnt] = '0; m_busy[m_cnt] = 1'b0;
      if (m_cnt == 31) m_clr = 1'b0;
      m_cnt++;
    end
  endtask

  initial begin
    logic [31:0] d0, d1;
    logic        b0, b1;
    int          k;

    //           we    waddr  wdata          rsv   raddr  ra0    ra1    e0             e1             eb
    vecs[0]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd1,  32'h0,         32'h0,         2'b00};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd31, 5'd1,  32'h0,         32'h0,         2'b00};
    vecs[2]  = '{1'b1, 5'd7,  32'hDEADBEEF,  1'b0, 5'd0,  5'd0,  5'd7,  32'h0,         32'hDEADBEEF,  2'b00};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd7,  5'd7,  32'hDEADBEEF,  32'hDEADBEEF,  2'b00};
    vecs[4]  = '{1'b1, 5'd0,  32'h1234,      1'b0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         2'b00};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd7,  32'h0,         32'hDEADBEEF,  2'b00};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  5'd5,  5'd7,  32'h0,         32'hDEADBEEF,  2'b00};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd5,  5'd5,  32'h0,         32'h0,         2'b11};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd5,  5'd7,  32'h0,         32'hDEADBEEF,  2'b01};
    vecs[9]  = '{1'b1, 5'd5,  32'h55,        1'b0, 5'd0,  5'd5,  5'd4,  32'h55,        32'h0,         2'b00};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd5,  5'd5,  32'h55,        32'h55,        2'b00};
    vecs[11] = '{1'b1, 5'd9,  32'h99,        1'b1, 5'd9,  5'd9,  5'd5,  32'h99,        32'h55,        2'b01};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd9,  5'd9,  32'h99,        32'h99,        2'b11};
    vecs[13] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  5'd0,  5'd9,  32'h0,         32'h99,        2'b10};
    vecs[14] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         2'b00};
    vecs[15] = '{1'b1, 5'd9,  32'hAA,        1'b0, 5'd0,  5'd9,  5'd5,  32'hAA,        32'h55,        2'b00};
    vecs[16] = '{1'b1, 5'd31, 32'hFFFFFFFF,  1'b0, 5'd0,  5'd31, 5'd30, 32'hFFFFFFFF,  32'h0,         2'b00};
    vecs[17] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd31, 5'd9,  32'hFFFFFFFF,  32'hAA,        2'b00};

    idle_in();
    setrd(5'd0, 5'd0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #3;
    chk("reset_clr_busy", {31'b0, clr_busy}, 32'h0);

    // Directed table: one vector per cycle, outputs checked before the edge.
    for (int i = 0; i < 18; i++) begin
      W_en = vecs[i].we; Waddr = vecs[i].waddr; Data_In = vecs[i].wdata;
      Rsv_en = vecs[i].rsv; Rsv_addr = vecs[i].raddr;
      setrd(vecs[i].ra0, vecs[i].ra1);
      #3;
      chk($sformatf("vec%0d_d0", i), rd0(), vecs[i].e0);
      chk($sformatf("vec%0d_d1", i), rd1(), vecs[i].e1);
      chk($sformatf("vec%0d_busy", i), {30'b0, Rd_busy}, {30'b0, vecs[i].eb});
      tick();
    end
    idle_in();

    // Bulk clear: fill entries with index+1, reserve entry 6, then sweep.
    for (int i = 0; i < 32; i++) begin
      W_en = 1'b1; Waddr = 5'(i); Data_In = 32'(i + 1);
      Rsv_en = (i == 20); Rsv_addr = 5'd6;
      tick();
    end
    idle_in();
    setrd(5'd6, 5'd12);
    #3;
    chk("pre_clear_busy6", {31'b0, Rd_busy[0]}, 32'h1);
    chk("pre_clear_d12", rd1(), 32'd13);
    clr_req = 1'b1;
    chk("pre_clear_clr_busy", {31'b0, clr_busy}, 32'h0);
    tick();
    clr_req = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      idle_in();
      if (c == 10) begin
        W_en = 1'b1; Waddr = 5'd3; Data_In = 32'hBAD0BAD0;
        Rsv_en = 1'b1; Rsv_addr = 5'd4;
      end
      if (c == 12) begin
        W_en = 1'b1; Waddr = 5'd11; Data_In = 32'hBAD1BAD1;
      end
      if (c == 15 || c == 32) clr_req = 1'b1;
      setrd(5'(c - 2), 5'(c - 1));
      #3;
      chk($sformatf("clr_c%0d_clr_busy", c), {31'b0, clr_busy}, {31'b0, (c <= 32)});
      if (c >= 2 && c <= 33) chk($sformatf("clr_c%0d_cleared", c), rd0(), 32'h0);
      if (c >= 2 && c <= 32) chk($sformatf("clr_c%0d_old", c), rd1(), 32'(c));
      tick();
    end
    idle_in();
    setrd(5'd3, 5'd4);
    #3;
    chk("clr_dropped_write3", rd0(), 32'h0);
    chk("clr_dropped_rsv4", {30'b0, Rd_busy}, 32'h0);
    setrd(5'd6, 5'd31);
    #3;
    chk("clr_busy6_cleared", {30'b0, Rd_busy}, 32'h0);
    chk("clr_d31", rd1(), 32'h0);

    // Reset in the middle of a clear.
    W_en = 1'b1; Waddr = 5'd20; Data_In = 32'h2020; tick();
    W_en = 1'b1; Waddr = 5'd30; Data_In = 32'h3030; tick();
    idle_in();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c <= 11; c++) tick();
    reset = 1'b1; clr_req = 1'b1;
    W_en = 1'b1; Waddr = 5'd25; Data_In = 32'h2525;
    tick();
    idle_in();
    clr_req = 1'b1;
    setrd(5'd20, 5'd30);
    #3;
    chk("rst_mid_d20", rd0(), 32'h0);
    chk("rst_mid_d30", rd1(), 32'h0);
    chk("rst_mid_clr_busy", {31'b0, clr_busy}, 32'h0);
    tick();
    clr_req = 1'b0;
    chk("rst_mid_restart", {31'b0, clr_busy}, 32'h1);
    k = 1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (!clr_busy) break;
      k++;
    end
    chk("rst_mid_clear_len", 32'(k), 32'd32);
    setrd(5'd25, 5'd1);
    #3;
    chk("rst_dominates_write", rd0(), 32'h0);

    // Randomised run against the behavioural model.
    for (int n = 0; n < 2000; n++) begin
      reset   = (n == 0) || ($urandom_range(199) == 0);
      W_en    = $urandom_range(1);
      Waddr   = 5'($urandom_range(31));
      Data_In = $urandom;
      Rsv_en  = ($urandom_range(2) == 0);
      Rsv_addr = ($urandom_range(3) == 0) ? Waddr : 5'($urandom_range(31));
      clr_req = ($urandom_range(63) == 0);
      setrd(($urandom_range(2) == 0) ? Waddr : 5'($urandom_range(31)),
            ($urandom_range(2) == 0) ? Rsv_addr : 5'($urandom_range(31)));
      #3;
      if (n > 0) begin
        exp_rd(Rd_Addr[4:0], d0, b0);
        exp_rd(Rd_Addr[9:5], d1, b1);
        chk($sformatf("rnd%0d_d0", n), rd0(), d0);
        chk($sformatf("rnd%0d_d1", n), rd1(), d1);
        chk($sformatf("rnd%0d_busy", n), {30'b0, Rd_busy}, {30'b0, b1, b0});
        chk($sformatf("rnd%0d_clr_busy", n), {31'b0, clr_busy}, {31'b0, m_clr});
      end
      tick();
      model_step();
    end
    idle_in();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
